// File: rtl/box_arbiter.sv
// Read/write port arbiter for the 512x3 box pixel RAM: display scanout vs game logic
// on the read port, game logic vs fill sequencer (BOX_ARBITER_FILL_EN) on the write port.
module box_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 3,
  parameter int MAX_WAIT = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          dispReq,
  input  logic [AW-1:0] dispAddr,
  output logic          dispGnt,
  output logic          dispValid,
  output logic [DW-1:0] dispData,
  input  logic          logicReq,
  input  logic          logicWe,
  input  logic [AW-1:0] logicAddr,
  input  logic [DW-1:0] logicWData,
  output logic          logicAck,
  output logic          logicRValid,
  output logic [DW-1:0] logicRData,
  input  logic          fillStart,
  input  logic [DW-1:0] fillValue,
  output logic          fillBusy,
  output logic          fillDone,
  output logic          boxWE,
  output logic          boxRE,
  output logic [AW-1:0] boxWAddr,
  output logic [AW-1:0] boxRAddr,
  output logic [DW-1:0] boxDataIn,
  input  logic [DW-1:0] boxDataOut
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_LOGIC} rd_tag_e;

  logic          logic_rd, logic_wr, logic_rd_win, disp_win, wr_ack;
  logic          fill_busy, fill_done, fill_we;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  rd_tag_e       rd_tag_q, rd_tag_d;

  // NOTE: every signal of this block is assigned before any branch, so no latch is inferred.
  always_comb begin
    logic_rd     = logicReq & ~logicWe & reset_n;
    logic_wr     = logicReq & logicWe & reset_n;
    logic_rd_win = logic_rd & (~dispReq | (wait_cnt_q == WW'(MAX_WAIT)));
    disp_win     = dispReq & reset_n & ~logic_rd_win;
    wr_ack       = logic_wr & ~fill_busy;

    wait_cnt_d = wait_cnt_q;
    if (logic_rd_win | wr_ack)
      wait_cnt_d = '0;
    else if (logic_rd && wait_cnt_q != WW'(MAX_WAIT))
      wait_cnt_d = wait_cnt_q + WW'(1);

    // The tag remembers who owns the data the RAM returns next cycle.
    rd_tag_d = disp_win ? TAG_DISP : (logic_rd_win ? TAG_LOGIC : TAG_NONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      rd_tag_q   <= TAG_NONE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

`ifdef BOX_ARBITER_FILL_EN
  typedef enum logic {IDLE, FILL} fill_state_e;

  fill_state_e   state_q, state_d;
  logic [AW-1:0] fill_addr_q, fill_addr_d;
  logic [DW-1:0] fill_val_q, fill_val_d;
  logic          fill_done_q, fill_done_d;

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_val_d  = fill_val_q;
    fill_done_d = 1'b0;
    case (state_q)
      IDLE: if (fillStart) begin
        state_d     = FILL;
        fill_addr_d = '0;
        fill_val_d  = fillValue;
      end
      FILL: begin
        // Hold the address on the last entry instead of wrapping to 0.
        if (fill_addr_q == {AW{1'b1}}) begin
          state_d     = IDLE;
          fill_done_d = 1'b1;
        end else begin
          fill_addr_d = fill_addr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
      fill_val_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      fill_val_q  <= fill_val_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign fill_busy = (state_q == FILL);
  assign fill_we   = fill_busy;
  assign fill_done = fill_done_q;
  assign fill_addr = fill_addr_q;
  assign fill_data = fill_val_q;
`else
  logic unused_fill;
  assign unused_fill = ^{fillStart, fillValue};
  assign fill_busy   = 1'b0;
  assign fill_we     = 1'b0;
  assign fill_done   = 1'b0;
  assign fill_addr   = '0;
  assign fill_data   = '0;
`endif

  assign dispGnt     = disp_win;
  assign logicAck    = logic_rd_win | wr_ack;
  assign boxRE       = disp_win | logic_rd_win;
  assign boxRAddr    = logic_rd_win ? logicAddr : (disp_win ? dispAddr : '0);
  assign boxWE       = wr_ack | fill_we;
  assign boxWAddr    = fill_we ? fill_addr : (wr_ack ? logicAddr : '0);
  assign boxDataIn   = fill_we ? fill_data : (wr_ack ? logicWData : '0);
  assign dispValid   = (rd_tag_q == TAG_DISP);
  assign dispData    = dispValid ? boxDataOut : '0;
  assign logicRValid = (rd_tag_q == TAG_LOGIC);
  assign logicRData  = logicRValid ? boxDataOut : '0;
  assign fillBusy    = fill_busy;
  assign fillDone    = fill_done;

endmodule
